// File: rtl/rs232_pkg.sv
// rs232_pkg: frame geometry and transmit state type shared by the RS232 transmit
// and receive sides.
package rs232_pkg;
  localparam int RS232_DATA_BITS = 8;
  localparam int RS232_FRAME_BITS = 10;
  localparam int RS232_OVERSAMPLE_DEFAULT = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} rs232_tx_state_t;
endpackage

// File: rtl/rs232_bit_timer.sv
// rs232_bit_timer: counts Clock16x cycles within one bit time and flags the last
// cycle of each bit.
module rs232_bit_timer import rs232_pkg::*; #(
  parameter int OVERSAMPLE = RS232_OVERSAMPLE_DEFAULT
) (
  input  logic Clock16x,
  input  logic Reset,
  input  logic restart,
  output logic bit_end
);
  localparam int W = $clog2(OVERSAMPLE);
  logic [W-1:0] cnt;
  assign bit_end = cnt == W'(OVERSAMPLE - 1);
  always_ff @(posedge Clock16x or negedge Reset)
    if (!Reset) cnt <= '0;
    else cnt <= (restart || bit_end) ? '0 : cnt + W'(1);
endmodule

// File: rtl/rs232_word_txd.sv
// rs232_word_txd: sends one 16-bit word per Send as two back-to-back 8N1 frames
// on Txd, first byte then second byte, with optional mark gap between them.
module rs232_word_txd import rs232_pkg::*; #(
  parameter int OVERSAMPLE = RS232_OVERSAMPLE_DEFAULT,
  parameter int GAP_BITS = 0
) (
  input  logic                       Clock16x,
  input  logic                       Reset,
  input  logic                       Send,
  input  logic [RS232_DATA_BITS-1:0] DataIn1,
  input  logic [RS232_DATA_BITS-1:0] DataIn2,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Txd
);
  localparam logic [2:0] GAP_LAST = 3'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
  rs232_tx_state_t state, state_next;
  logic [RS232_DATA_BITS-1:0] shift, shift_next, hold;
  logic [2:0] idx, idx_next;
  logic sel, sel_next, bit_end, accept, load2, txd_next, busy_next, done_next;
  rs232_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .Clock16x(Clock16x),
    .Reset(Reset),
    .restart(state_next != state),
    .bit_end(bit_end)
  );
  always_ff @(posedge Clock16x or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = Send ? START : IDLE;
      START:   state_next = bit_end ? DATA : START;
      DATA:    state_next = (bit_end && idx == 3'd7) ? STOP : DATA;
      STOP:    state_next = !bit_end ? STOP : sel ? IDLE : (GAP_BITS > 0) ? GAP : START;
      GAP:     state_next = (bit_end && idx == GAP_LAST) ? START : GAP;
      default: state_next = IDLE;
    endcase
  end
  // The bit index doubles as the gap bit counter; it is back at 0 after each byte.
  assign accept = state == IDLE && Send;
  assign load2 = state_next == START && (state == STOP || state == GAP);
  always_comb begin
    shift_next = accept ? DataIn1 : load2 ? hold : (state == DATA && bit_end) ? shift >> 1 : shift;
    idx_next = ((state == DATA || state == GAP) && bit_end) ? (state_next == state ? idx + 3'd1 : 3'd0) : idx;
    sel_next = accept ? 1'b0 : load2 ? 1'b1 : sel;
  end
  // Txd is registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    txd_next = state_next == START ? 1'b0 : state_next == DATA ? shift_next[0] : 1'b1;
    busy_next = state_next != IDLE;
    done_next = state == STOP && sel && bit_end;
  end
  always_ff @(posedge Clock16x or negedge Reset)
    if (!Reset) begin
      shift <= '0;
      hold <= '0;
      idx <= '0;
      sel <= 1'b0;
      Txd <= 1'b1;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      shift <= shift_next;
      hold <= accept ? DataIn2 : hold;
      idx <= idx_next;
      sel <= sel_next;
      Txd <= txd_next;
      Busy <= busy_next;
      Done <= done_next;
    end
endmodule

// File: tb/tb_rs232_word_txd.sv
// tb_rs232_word_txd: drives words into three transmitter configurations (default,
// two gap bits, 8x oversampling) and checks the serial line against queued words.
module tb_rs232_word_txd;
  typedef struct {int ch; logic [7:0] a; logic [7:0] b;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] send;
  logic [7:0] d1 [3];
  logic [7:0] d2 [3];
  wire [2:0] busy, done, txd;
  exp_t exp_q [$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, got, want, cyc);
  endtask
  for (genvar g = 0; g < 3; g++) begin : ch
    localparam int os = (g == 2) ? 8 : 16;
    localparam int gp = (g == 1) ? 2 : 0;
    localparam int tt = (20 + gp) * os;
    rs232_word_txd #(.OVERSAMPLE(os), .GAP_BITS(gp)) dut (
      .Clock16x(clk),
      .Reset(rst_n),
      .Send(send[g]),
      .DataIn1(d1[g]),
      .DataIn2(d2[g]),
      .Busy(busy[g]),
      .Done(done[g]),
      .Txd(txd[g])
    );
    logic ln [0:tt];
    logic dn [0:tt];
    logic by [0:tt];
    initial begin : mon
      int n, b2, bad_t, bad_b, bad_d;
      exp_t e;
      logic [19:0] got, want;
      logic [9:0] f1, f2;
      logic wt;
      forever begin
        @(negedge clk);
        if (rst_n && !txd[g]) begin
          n = 0;
          while (n <= tt) begin
            if (n > 0) @(negedge clk);
            if (!rst_n) break;
            ln[n] = txd[g];
            dn[n] = done[g];
            by[n] = busy[g];
            n++;
          end
          if (n == tt + 1) begin
            chk("queue_has_word", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("word_channel", g, e.ch);
              f1 = {1'b1, e.a, 1'b0};
              f2 = {1'b1, e.b, 1'b0};
              b2 = (10 + gp) * os;
              for (int j = 0; j < 10; j++) begin
                got[j] = ln[j * os + os / 2];
                got[j + 10] = ln[b2 + j * os + os / 2];
              end
              want = {f2, f1};
              chk("bit_centres", got, want);
              bad_t = 0;
              bad_b = 0;
              bad_d = 0;
              for (int i = 0; i <= tt; i++) begin
                wt = i < 10 * os ? f1[i / os] : i < b2 ? 1'b1 : i < tt ? f2[(i - b2) / os] : 1'b1;
                bad_t += int'(ln[i] != wt);
                bad_b += int'(by[i] != (i < tt));
                bad_d += int'(dn[i] != (i == tt));
              end
              chk("txd_waveform_bad_cycles", bad_t, 0);
              chk("busy_window_bad_cycles", bad_b, 0);
              chk("done_timing_bad_cycles", bad_d, 0);
            end
          end
        end
      end
    end
  end
  task automatic wait_done(input int c);
    int k;
    k = 0;
    while (!done[c] && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done[c], 1);
    @(negedge clk);
  endtask
  task automatic send_word(input int c, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    d1[c] = a;
    d2[c] = b;
    send[c] = 1'b1;
    exp_q.push_back('{c, a, b});
    @(negedge clk);
    send[c] = 1'b0;
    d1[c] = ~a;
    d2[c] = b ^ 8'h5A;
    wait_done(c);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int e0, ne, k, hits;
    rst_n = 1'b0;
    send = '0;
    for (int i = 0; i < 3; i++) begin
      d1[i] = '0;
      d2[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 3'b111);
    chk("reset_busy", busy, 3'b000);
    chk("reset_done", done, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_word(0, 8'hA5, 8'h3C);
    send_word(0, 8'h00, 8'hFF);
    send_word(0, 8'h55, 8'hAA);
    @(negedge clk);
    e0 = cyc + 1;
    k = 0;
    send[0] = 1'b1;
    while (k < 3) begin
      ne = cyc + 1;
      d1[0] = 8'(ne) ^ 8'h5A;
      d2[0] = ~8'(ne);
      if ((ne - e0) % 321 == 0) begin
        exp_q.push_back('{0, 8'(ne) ^ 8'h5A, ~8'(ne)});
        k++;
      end
      @(negedge clk);
    end
    send[0] = 1'b0;
    wait_done(0);
    @(negedge clk);
    chk("busy_after_burst", busy[0], 0);
    d1[0] = 8'hC3;
    d2[0] = 8'h96;
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_txd", txd[0], 0);
    chk("pre_reset_busy", busy[0], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd", txd[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      hits += int'(done[0] || busy[0] || !txd[0]);
    end
    chk("abort_no_activity", hits, 0);
    send_word(0, 8'h12, 8'h34);
    send_word(1, 8'hA5, 8'h3C);
    send_word(2, 8'hA5, 8'h3C);
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
